neighbor_table_updater: RTL and testbench

//  Sequencer sitting directly upstream of the node memory (16-bit word port, byte address, combinational read).
//  On each received beacon it searches the neighborID table for the sender.
//  Hit: overwrites that entry's clusterID/batteryStat/qValue. Miss: appends a new entry.

---
 rtl/neighbor_table_updater_pkg.sv | 26 ++
 rtl/neighbor_table_updater.sv | 176 +++++++++++++++++
 tb/tb_neighbor_table_updater.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_table_updater_pkg.sv
// ============================================================================
// neighbor_table_updater_pkg : node-memory address map shared with the memory
// Revision: 1.0
// ============================================================================
`default_nettype none

package neighbor_table_updater_pkg;

    localparam int          WORD_WIDTH       = 16;
    localparam int          NTU_MAX_NEIGH    = 64;
    localparam int          IDX_W            = 6;
    localparam int          CNT_W            = 7;
    localparam logic [15:0] NTU_NEIGH_BASE   = 16'h0048;
    localparam logic [15:0] NTU_CLUSTER_BASE = 16'h00C8;
    localparam logic [15:0] NTU_BATT_BASE    = 16'h0148;
    localparam logic [15:0] NTU_QVAL_BASE    = 16'h01C8;

    // Byte address of a 2-byte table entry.
    function automatic logic [15:0] entry_addr(input logic [15:0] base,
                                               input logic [IDX_W-1:0] idx);
        return base + {{(16-IDX_W-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/neighbor_table_updater.sv
// ============================================================================
// neighbor_table_updater : beacon-driven search/update/append of neighbor table
// Revision: 1.0
// ============================================================================
`default_nettype none

module neighbor_table_updater
    import neighbor_table_updater_pkg::*;
#(
    parameter int          MAX_NEIGH    = NTU_MAX_NEIGH,
    parameter logic [15:0] NEIGH_BASE   = NTU_NEIGH_BASE,
    parameter logic [15:0] CLUSTER_BASE = NTU_CLUSTER_BASE,
    parameter logic [15:0] BATT_BASE    = NTU_BATT_BASE,
    parameter logic [15:0] QVAL_BASE    = NTU_QVAL_BASE
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_id,
    input  logic [WORD_WIDTH-1:0] in_cluster,
    input  logic [WORD_WIDTH-1:0] in_batt,
    input  logic [WORD_WIDTH-1:0] in_qval,
    output logic [15:0]           mem_address,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  hit,
    output logic                  full,
    output logic [IDX_W-1:0]      entry_idx,
    output logic [CNT_W-1:0]      neigh_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_WR_ID  = 3'd2,
        S_WR_CL  = 3'd3,
        S_WR_BAT = 3'd4,
        S_WR_Q   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_NEIGH);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_WIDTH-1:0] r_id;
    logic [WORD_WIDTH-1:0] r_cl;
    logic [WORD_WIDTH-1:0] r_bt;
    logic [WORD_WIDTH-1:0] r_q;
    logic                  r_hit;
    logic                  r_full;
    logic [IDX_W-1:0]      r_entry_idx;

    logic                  w_at_end;
    logic                  w_match;
    logic [15:0]           w_addr;
    logic                  w_wr_en;
    logic [WORD_WIDTH-1:0] w_wdata;

    assign w_at_end = (r_idx == r_count);
    assign w_match  = (mem_rdata == r_id);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_id        <= '0;
            r_cl        <= '0;
            r_bt        <= '0;
            r_q         <= '0;
            r_hit       <= 1'b0;
            r_full      <= 1'b0;
            r_entry_idx <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_id        <= in_id;
                        r_cl        <= in_cluster;
                        r_bt        <= in_batt;
                        r_q         <= in_qval;
                        r_idx       <= '0;
                        r_hit       <= 1'b0;
                        r_full      <= 1'b0;
                        r_entry_idx <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_at_end) begin
                        if (r_count == C_MAX) r_full <= 1'b1;
                        else                  r_entry_idx <= r_idx[IDX_W-1:0];
                    end else if (w_match) begin
                        r_hit       <= 1'b1;
                        r_entry_idx <= r_idx[IDX_W-1:0];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                // A new entry only becomes live once its last field is written.
                S_WR_Q: begin
                    if (!r_hit) r_count <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_addr       = '0;
        w_wr_en      = 1'b0;
        w_wdata      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_SCAN;
            end
            S_SCAN: begin
                w_addr = entry_addr(NEIGH_BASE, r_idx[IDX_W-1:0]);
                if (w_at_end)
                    w_next_state = (r_count == C_MAX) ? S_DONE : S_WR_ID;
                else if (w_match)
                    w_next_state = S_WR_CL;
            end
            S_WR_ID: begin
                w_addr       = entry_addr(NEIGH_BASE, r_idx[IDX_W-1:0]);
                w_wr_en      = 1'b1;
                w_wdata      = r_id;
                w_next_state = S_WR_CL;
            end
            S_WR_CL: begin
                w_addr       = entry_addr(CLUSTER_BASE, r_idx[IDX_W-1:0]);
                w_wr_en      = 1'b1;
                w_wdata      = r_cl;
                w_next_state = S_WR_BAT;
            end
            S_WR_BAT: begin
                w_addr       = entry_addr(BATT_BASE, r_idx[IDX_W-1:0]);
                w_wr_en      = 1'b1;
                w_wdata      = r_bt;
                w_next_state = S_WR_Q;
            end
            S_WR_Q: begin
                w_addr       = entry_addr(QVAL_BASE, r_idx[IDX_W-1:0]);
                w_wr_en      = 1'b1;
                w_wdata      = r_q;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mem_address = w_addr;
    assign mem_wr_en   = w_wr_en;
    assign mem_wdata   = w_wdata;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign hit         = r_hit;
    assign full        = r_full;
    assign entry_idx   = r_entry_idx;
    assign neigh_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_neighbor_table_updater.sv
// ============================================================================
// tb_neighbor_table_updater : vector table, random requests vs. table model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neighbor_table_updater;

    localparam logic [15:0] T_NEIGH = 16'h0048;
    localparam logic [15:0] T_CL    = 16'h00C8;
    localparam logic [15:0] T_BT    = 16'h0148;
    localparam logic [15:0] T_Q     = 16'h01C8;
    localparam int          T_MAX   = 64;

    logic        clock = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] in_id, in_cluster, in_batt, in_qval;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_wr_en, busy, done, hit, full;
    logic [5:0]  entry_idx;
    logic [6:0]  neigh_count;

    neighbor_table_updater dut (
        .clock      (clock),
        .nrst       (nrst),
        .start      (start),
        .in_id      (in_id),
        .in_cluster (in_cluster),
        .in_batt    (in_batt),
        .in_qval    (in_qval),
        .mem_address(mem_address),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .full       (full),
        .entry_idx  (entry_idx),
        .neigh_count(neigh_count)
    );

    always #5 clock = ~clock;

    // Node memory: 16-bit words, byte address, combinational read.
    logic [15:0]  mem [0:1023];
    logic [31:0]  wr_log[$];
    int           done_cnt = 0;
    assign mem_rdata = mem[mem_address[10:1]];

    always @(posedge clock) begin
        if (mem_wr_en) begin
            mem[mem_address[10:1]] <= mem_wdata;
            wr_log.push_back({mem_address, mem_wdata});
        end
        if (done) done_cnt++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: ordered list of live entries.
    logic [15:0] m_id [T_MAX];
    logic [15:0] m_cl [T_MAX];
    logic [15:0] m_bt [T_MAX];
    logic [15:0] m_q  [T_MAX];
    int          m_n = 0;
    logic [31:0] exp_wr[$];
    bit          e_hit, e_full;
    int          e_idx, e_lat;

    task automatic model_req(input logic [15:0] id, cl, bt, q);
        int k;
        k = -1;
        exp_wr.delete();
        e_hit = 0; e_full = 0; e_idx = 0;
        for (int i = 0; i < m_n; i++)
            if (k < 0 && m_id[i] == id) k = i;
        if (k >= 0) begin
            e_hit = 1; e_idx = k; e_lat = k + 5;
        end else if (m_n == T_MAX) begin
            e_full = 1; e_lat = T_MAX + 2;
        end else begin
            k = m_n; e_idx = k; e_lat = m_n + 6;
            m_id[k] = id;
            m_n++;
            exp_wr.push_back({16'(T_NEIGH + 2 * k), id});
        end
        if (!e_full) begin
            m_cl[k] = cl; m_bt[k] = bt; m_q[k] = q;
            exp_wr.push_back({16'(T_CL + 2 * k), cl});
            exp_wr.push_back({16'(T_BT + 2 * k), bt});
            exp_wr.push_back({16'(T_Q  + 2 * k), q});
        end
    endtask

    bit g_hit, g_full, g_busy, g_to;
    int g_idx, g_lat, g_cnt;

    // Issue one request; optionally pulse start while busy.
    task automatic run_req(input logic [15:0] id, cl, bt, q, input bit pulse);
        int lat;
        int d0;
        @(negedge clock);
        in_id = id; in_cluster = cl; in_batt = bt; in_qval = q;
        start = 1'b1;
        wr_log.delete();
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b0;
        in_id = ~id; in_cluster = 16'($urandom); in_batt = 16'($urandom); in_qval = 16'($urandom);
        lat = 1; g_to = 0;
        while (done !== 1'b1) begin
            if (lat > 200) begin g_to = 1; break; end
            if (pulse) begin
                start = lat[0];
                in_id = 16'($urandom);
            end
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        g_lat = lat; g_hit = hit; g_full = full; g_idx = int'(entry_idx);
        g_cnt = int'(neigh_count); g_busy = busy;
        if (g_to) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no done within 200 cycles expected done for id 0x%0h", id);
        end
        @(posedge clock); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("dones_per_request", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_result(input string tag, input bit xh, xf, input int xi, xc, xl);
        chk({tag, "_hit"},   {31'd0, g_hit},  {31'd0, xh});
        chk({tag, "_full"},  {31'd0, g_full}, {31'd0, xf});
        chk({tag, "_idx"},   32'(g_idx), 32'(xi));
        chk({tag, "_count"}, 32'(g_cnt), 32'(xc));
        chk({tag, "_lat"},   32'(g_lat), 32'(xl));
        chk({tag, "_busy"},  {31'd0, g_busy}, 32'd1);
        chk({tag, "_nwr"},   32'(wr_log.size()), 32'(exp_wr.size()));
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
    endtask

    task automatic model_run(input string tag, input logic [15:0] id, cl, bt, q, input bit pulse);
        model_req(id, cl, bt, q);
        run_req(id, cl, bt, q, pulse);
        check_result(tag, e_hit, e_full, e_idx, m_n, e_lat);
    endtask

    typedef struct {
        logic [15:0] id, cl, bt, q;
        bit          hit, full;
        int          idx, cnt, lat;
    } vec_t;
    vec_t tv[5];

    initial begin
        tv[0] = '{16'h0011, 16'h0002, 16'h0064, 16'h0007, 1'b0, 1'b0, 0, 1, 6};
        tv[1] = '{16'h0011, 16'h0002, 16'h0064, 16'h0009, 1'b1, 1'b0, 0, 1, 5};
        tv[2] = '{16'h0022, 16'h0003, 16'h0050, 16'h0001, 1'b0, 1'b0, 1, 2, 7};
        tv[3] = '{16'h0022, 16'h0004, 16'h0051, 16'h0004, 1'b1, 1'b0, 1, 2, 6};
        tv[4] = '{16'h0011, 16'h0005, 16'h0052, 16'h0005, 1'b1, 1'b0, 0, 2, 5};

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        start = 0; in_id = 0; in_cluster = 0; in_batt = 0; in_qval = 0;
        nrst = 1'b1;
        #2 nrst = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_flags", {29'd0, hit, full, 1'b0} | {26'd0, entry_idx}, 32'd0);
        chk("rst_count", {25'd0, neigh_count}, 32'd0);
        chk("rst_addr",  {16'd0, mem_address}, 32'd0);
        @(negedge clock) nrst = 1'b1;

        // Directed vectors, incl. miss on empty table and hit updating qValue.
        for (int i = 0; i < 5; i++) begin
            model_req(tv[i].id, tv[i].cl, tv[i].bt, tv[i].q);
            run_req(tv[i].id, tv[i].cl, tv[i].bt, tv[i].q, 1'b0);
            check_result($sformatf("vec%0d", i), tv[i].hit, tv[i].full, tv[i].idx, tv[i].cnt, tv[i].lat);
        end
        chk("vec1_qval_mem", {16'd0, mem[T_Q >> 1]}, 32'd5);

        // Random requests over a small id pool so hits and misses mix.
        for (int i = 0; i < 40; i++)
            model_run("rand", 16'h0100 + 16'($urandom_range(0, 11)), 16'($urandom),
                      16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        // Reset during the batteryStat write of a miss.
        @(negedge clock);
        in_id = 16'h0077; in_cluster = 16'h1; in_batt = 16'h2; in_qval = 16'h3;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (mem_wr_en && mem_address == 16'(T_BT + 2 * m_n)) break;
            @(posedge clock); #1;
        end
        chk("midrst_reached_wr_bat", {31'd0, mem_wr_en}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("midrst_busy",  {31'd0, busy}, 32'd0);
        chk("midrst_count", {25'd0, neigh_count}, 32'd0);
        chk("midrst_outs",  {16'd0, mem_address} | {26'd0, entry_idx} | {29'd0, hit, full, done}, 32'd0);
        m_n = 0;
        @(negedge clock) nrst = 1'b1;
        model_run("post_rst", 16'h0077, 16'h1, 16'h2, 16'h3, 1'b0);
        chk("post_rst_idx0_addr", {16'd0, wr_log.size() > 0 ? wr_log[0][31:16] : 16'hFFFF}, {16'd0, T_NEIGH});

        // Fill the table, then a miss on a full table, then a hit on the last entry.
        for (int i = 1; i < T_MAX; i++)
            model_run("fill", 16'h1000 + 16'(i), 16'(i), 16'(i + 1), 16'(i + 2), 1'b0);
        model_run("full", 16'hBEEF, 16'h1, 16'h2, 16'h3, 1'b1);
        check_result("full_exp", 1'b0, 1'b1, 0, 64, 66);
        model_run("last", 16'h1000 + 16'd63, 16'hA, 16'hB, 16'hC, 1'b0);
        check_result("last_exp", 1'b1, 1'b0, 63, 64, 68);
        if (wr_log.size() == 3) begin
            chk("last_cl_addr", {16'd0, wr_log[0][31:16]}, 32'h146);
            chk("last_bt_addr", {16'd0, wr_log[1][31:16]}, 32'h1C6);
            chk("last_q_addr",  {16'd0, wr_log[2][31:16]}, 32'h246);
        end

        for (int i = 0; i < T_MAX; i++) begin
            chk("mem_id", {16'd0, mem[(T_NEIGH + 2 * i) >> 1]}, {16'd0, m_id[i]});
            chk("mem_cl", {16'd0, mem[(T_CL + 2 * i) >> 1]},    {16'd0, m_cl[i]});
            chk("mem_bt", {16'd0, mem[(T_BT + 2 * i) >> 1]},    {16'd0, m_bt[i]});
            chk("mem_q",  {16'd0, mem[(T_Q + 2 * i) >> 1]},     {16'd0, m_q[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
